// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one single-port RAM between two req/ack ports
module ram_arbiter #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             we_a,
  input  logic [AW-1:0]    addr_a,
  input  logic [WIDTH-1:0] wdata_a,
  output logic             ack_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic             req_b,
  input  logic             we_b,
  input  logic [AW-1:0]    addr_b,
  input  logic [WIDTH-1:0] wdata_b,
  output logic             ack_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             busy,
  output logic             ram_load,
  output logic [AW-1:0]    ram_address,
  output logic [WIDTH-1:0] ram_in,
  input  logic [WIDTH-1:0] ram_out
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic we_q, grant_q, pick_b;
  logic [AW-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  // grant_q doubles as last_grant; resetting it to B lets A win the first tie
  assign pick_b = req_b & (~req_a | ~grant_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? ((req_a | req_b) ? ACCESS : IDLE) :
               state == ACCESS ? DONE : IDLE;
  always_comb begin
    busy = state != IDLE;
    ram_load = state == ACCESS && we_q;
    ram_address = addr_q;
    ram_in = wdata_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      grant_q <= 1'b1;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      ack_a <= state == ACCESS && !grant_q;
      ack_b <= state == ACCESS && grant_q;
      if (state == IDLE && (req_a | req_b)) begin
        grant_q <= pick_b;
        we_q <= pick_b ? we_b : we_a;
        addr_q <= pick_b ? addr_b : addr_a;
        wdata_q <= pick_b ? wdata_b : wdata_a;
      end
      if (state == ACCESS && !we_q) begin
        if (grant_q) rdata_b <= ram_out;
        else rdata_a <= ram_out;
      end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed test of ram_arbiter against a behavioural single-port RAM
module tb_ram_arbiter;
  logic clk = 0, rst_n = 0;
  logic req_a = 0, we_a = 0, req_b = 0, we_b = 0;
  logic [4:0] addr_a = 0, addr_b = 0;
  logic [15:0] wdata_a = 0, wdata_b = 0;
  logic ack_a, ack_b, busy, ram_load;
  logic [15:0] rdata_a, rdata_b, ram_in, ram_out;
  logic [4:0] ram_address;
  logic [15:0] mem [32];
  int n_chk = 0, n_fail = 0;
  int ca, cb, n;
  logic [5:0] seq;

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .ack_a(ack_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .ack_b(ack_b), .rdata_b(rdata_b),
    .busy(busy), .ram_load(ram_load), .ram_address(ram_address), .ram_in(ram_in), .ram_out(ram_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;
  assign ram_out = mem[ram_address];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 0; req_a = 0; req_b = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // one transaction from IDLE; returns on the negedge after ack, back in IDLE
  task automatic xfer(input bit pb, input logic w, input logic [4:0] a, input logic [15:0] d);
    bit got = 0;
    if (pb) begin req_b = 1; we_b = w; addr_b = a; wdata_b = d; end
    else begin req_a = 1; we_a = w; addr_a = a; wdata_a = d; end
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = pb ? ack_b : ack_a;
    end
    req_a = 0; req_b = 0;
    if (!got) chk("xfer_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    do_reset();
    chk("rst_ack_a", ack_a, 0);
    chk("rst_ack_b", ack_b, 0);
    chk("rst_rdata_a", rdata_a, 0);
    chk("rst_rdata_b", rdata_b, 0);
    chk("rst_ram_load", ram_load, 0);
    chk("rst_ram_address", ram_address, 0);
    chk("rst_ram_in", ram_in, 0);
    chk("rst_busy", busy, 0);
    // test 1: single write then read
    req_a = 1; we_a = 1; addr_a = 3; wdata_a = 16'h1234;
    @(negedge clk);
    chk("t1_load_c1", ram_load, 1);
    chk("t1_addr_c1", ram_address, 3);
    chk("t1_ack_c1", ack_a, 0);
    chk("t1_busy_c1", busy, 1);
    @(negedge clk);
    chk("t1_load_c2", ram_load, 0);
    chk("t1_ack_c2", ack_a, 1);
    req_a = 0;
    @(negedge clk);
    chk("t1_ack_c3", ack_a, 0);
    chk("t1_busy_c3", busy, 0);
    xfer(0, 0, 3, 0);
    chk("t1_rdata_a", rdata_a, 16'h1234);
    chk("t1_rdata_b", rdata_b, 0);
    // test 2: simultaneous requests after reset
    do_reset();
    req_a = 1; we_a = 1; addr_a = 1; wdata_a = 16'hAAAA;
    req_b = 1; we_b = 1; addr_b = 2; wdata_b = 16'h5555;
    ca = 0; cb = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (ack_a) begin ca = c; req_a = 0; end
      if (ack_b) begin cb = c; req_b = 0; end
    end
    chk("t2_ack_a_cycle", ca, 2);
    chk("t2_ack_b_cycle", cb, 5);
    xfer(0, 0, 1, 0);
    chk("t2_rd1", rdata_a, 16'hAAAA);
    xfer(1, 0, 2, 0);
    chk("t2_rd2", rdata_b, 16'h5555);
    // test 3: both held, round robin
    req_a = 1; we_a = 0; addr_a = 1;
    req_b = 1; we_b = 0; addr_b = 2;
    n = 0; seq = 0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (ack_a | ack_b) begin seq = {seq[4:0], ack_b}; n++; end
    end
    req_a = 0; req_b = 0;
    chk("t3_count", n, 6);
    chk("t3_order", seq, 6'b010101);
    chk("t3_rdata_a", rdata_a, 16'hAAAA);
    chk("t3_rdata_b", rdata_b, 16'h5555);
    @(negedge clk);
    chk("t3_busy", busy, 0);
    // test 4: back-to-back B reads at DEPTH-1
    xfer(1, 1, 31, 16'hBEEF);
    req_b = 1; we_b = 0; addr_b = 31;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk("t4_ack_b", ack_b, (c % 3 == 2) ? 1 : 0);
      if (ack_b) chk("t4_rdata_b", rdata_b, 16'hBEEF);
    end
    req_b = 0;
    chk("t4_rdata_a", rdata_a, 16'hAAAA);
    @(negedge clk);
    // test 5: reset during ACCESS
    xfer(0, 1, 7, 16'h1111);
    req_a = 1; we_a = 1; addr_a = 7; wdata_a = 16'h7777;
    @(negedge clk);
    chk("t5_load_pre", ram_load, 1);
    #2 rst_n = 0;
    #1;
    chk("t5_load_rst", ram_load, 0);
    chk("t5_busy_rst", busy, 0);
    chk("t5_ack_rst", ack_a, 0);
    req_a = 0;
    @(negedge clk);
    chk("t5_ack_after", ack_a, 0);
    rst_n = 1;
    xfer(0, 0, 7, 0);
    chk("t5_rd7", rdata_a, 16'h1111);
    // test 6: cmd changes mid-flight
    req_a = 1; we_a = 1; addr_a = 9; wdata_a = 16'h9999;
    @(negedge clk);
    req_a = 0; addr_a = 10; wdata_a = 0;
    #1;
    chk("t6_addr", ram_address, 9);
    chk("t6_in", ram_in, 16'h9999);
    @(negedge clk);
    chk("t6_ack", ack_a, 1);
    @(negedge clk);
    xfer(0, 0, 9, 0);
    chk("t6_rd9", rdata_a, 16'h9999);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
